reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer that allocates the 3-bit rename tags the register file records as register dependencies.
- Captures execution results from the result bus and retires instructions in program order.
- Drives the register file's commit interface: commit, reg_num, data_in, num_in.
- Sits between issue/dispatch (upstream) and the register file commit port (downstream); tag 0 is reserved to mean "no dependency".

Parameters:
- TAG_W, 3, tag width; matches register file dependency width.
- DEPTH, 7, number of entries; tags 1..DEPTH, must equal 2^TAG_W-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (rst==0 resets)
- pause  input  1  global stall; freezes issue and commit
- flush  input  1  synchronous squash of all entries (mispredict)
- issue_valid  input  1  dispatch requests an entry
- issue_has_rd  input  1  instruction writes a destination register
- issue_rd  input  5  destination register number
- issue_ready  output  1  combinational: count<DEPTH && !pause && !flush
- issue_tag  output  TAG_W  combinational: current tail tag, valid when issue_ready
- wb_valid  input  1  result bus strobe
- wb_tag  input  TAG_W  tag of the producing entry
- wb_data  input  32  result value
- commit  output  1  registered one-cycle retire pulse to register file
- commit_reg  output  5  retired rd (0 if no rd)
- commit_data  output  32  retired value
- commit_tag  output  TAG_W  retired tag (register file num_in)
- count  output  TAG_W  occupied entries, 0..DEPTH

Behaviour:
- Reset (rst low, async): head=tail=1, count=0, all busy/ready bits 0, commit=0, commit_reg=0, commit_data=0, commit_tag=0.
- Entry state: busy, ready, has_rd, rd[4:0], data[31:0].
- Pointer increment: 1→2→…→DEPTH→1; tag 0 is never allocated.
- Issue fires on issue_valid && issue_ready at the edge:
  - entry[tail] gets busy=1, ready=0, has_rd, rd.
  - tail advances.
- Writeback: wb_valid with entry[wb_tag].busy sets ready=1, data=wb_data.
  - wb_tag 0 or a non-busy tag is ignored.
  - Writeback is captured even while pause=1, so results are never lost.
- Commit fires when !pause && !flush && entry[head].busy && entry[head].ready at the edge:
  - Next cycle: commit=1, commit_reg = has_rd ? rd : 0, commit_data=data, commit_tag=head.
  - entry[head] cleared; head advances.
  - Otherwise commit=0 and the other commit outputs hold their last values.
- Latency:
  - Writeback at edge N makes the entry eligible; commit pulse appears after edge N+1.
  - At most one retire per cycle.
- Simultaneous events:
  - Issue + commit in the same cycle: count unchanged. issue_ready is based on the pre-edge count, so a full buffer rejects issue even when a commit happens that cycle.
  - Writeback + commit to the same head entry: commit evaluates pre-edge ready and happens the following cycle.
  - Writeback targeting the tag being allocated in the same cycle is ignored; the entry was not busy.
- Count: increments on issue only, decrements on commit only, saturates neither way by construction. Full at count==DEPTH, empty at count==0.
- Flush (synchronous, priority over issue/commit/writeback):
  - All entries cleared; head=tail=1; count=0; commit=0 next cycle.
  - Writeback in the flush cycle is discarded.
- pause=1: head, tail and count hold, no issue, no commit (commit=0); only writeback updates entries.
- rst asserted mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- When defined, adds two read ports so operands tagged by the register file can be resolved from the buffer:
  - Inputs: q1_tag[TAG_W], q2_tag[TAG_W].
  - Outputs: q1_hit, q1_value[32], q2_hit, q2_value[32].
  - Each is combinational: hit = tag!=0 && busy && ready; value = entry data when hit, else 0.
  - Same-cycle wb_tag match with wb_valid also hits and returns wb_data.
- When undefined: those ports do not exist and no bypass logic is built.

Test Plan:
- Reset then issue rd=5 (tag 1), wb tag1 data=0x1234 → one cycle later commit=1, commit_reg=5, commit_data=0x1234, commit_tag=1.
- Issue 7 instructions (tags 1..7) → count=7, issue_ready=0. Writeback tag1, commit → count=6. Next issue gets tag 1 (wrap-around).
- Issue tags 1,2; writeback tag2 first, then tag1 → commits in order: tag1, then tag2 on consecutive cycles.
- Entries ready, pause=1 for 3 cycles with a writeback during pause → no commit during pause, writeback retained. Commits resume after pause drops.
- flush with 4 busy entries and a concurrent writeback → count=0, next issue_tag=1, no commit pulse.
- rst low asynchronously mid-burst (between clock edges) → outputs zero immediately. ROB_BYPASS_EN build: q1_tag=3 ready with 0xAB → q1_hit=1, q1_value=0xAB.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out rename tags 1..DEPTH, captures results, retires in order.
// Defining ROB_BYPASS_EN adds two combinational operand read ports (q1/q2) into the buffer.
module reorder_buffer #(
    parameter int TAG_W = 3,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic             issue_has_rd,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_data,
`ifdef ROB_BYPASS_EN
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_hit,
    output logic [31:0]      q1_value,
    output logic             q2_hit,
    output logic [31:0]      q2_value,
`endif
    output logic             commit,
    output logic [4:0]       commit_reg,
    output logic [31:0]      commit_data,
    output logic [TAG_W-1:0] commit_tag,
    output logic [TAG_W-1:0] count
);
    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t TAG_ONE  = tag_t'(1);
    localparam tag_t TAG_LAST = tag_t'(DEPTH);

    // Slot 0 exists only so every tag value indexes in range; it is never allocated.
    logic [DEPTH:0] busy_q, busy_d;
    logic [DEPTH:0] ready_q, ready_d;
    logic [DEPTH:0] has_rd_q;
    logic [4:0]     rd_q   [0:DEPTH];
    logic [31:0]    data_q [0:DEPTH];

    tag_t        head_q, head_d;
    tag_t        tail_q, tail_d;
    tag_t        count_q, count_d;
    logic        commit_q, commit_d;
    logic [4:0]  commit_reg_q, commit_reg_d;
    logic [31:0] commit_data_q, commit_data_d;
    tag_t        commit_tag_q, commit_tag_d;

    logic issue_fire, wb_fire, commit_fire;

    function automatic tag_t next_tag(input tag_t t);
        return (t == TAG_LAST) ? TAG_ONE : t + TAG_ONE;
    endfunction

    assign issue_ready = (count_q != TAG_LAST) && !pause && !flush;
    assign issue_tag   = tail_q;
    assign issue_fire  = issue_valid && issue_ready;
    assign wb_fire     = wb_valid && busy_q[wb_tag] && !flush;
    assign commit_fire = !pause && !flush && busy_q[head_q] && ready_q[head_q];

    always_comb begin
        // NOTE: every next-state signal is given its hold value first, so no path leaves one unassigned (no latch).
        busy_d        = busy_q;
        ready_d       = ready_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_d      = 1'b0;
        commit_reg_d  = commit_reg_q;
        commit_data_d = commit_data_q;
        commit_tag_d  = commit_tag_q;
        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = TAG_ONE;
            tail_d  = TAG_ONE;
            count_d = '0;
        end else begin
            if (wb_fire) begin
                ready_d[wb_tag] = 1'b1;
            end
            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = next_tag(head_q);
                commit_d        = 1'b1;
                commit_reg_d    = has_rd_q[head_q] ? rd_q[head_q] : 5'd0;
                commit_data_d   = data_q[head_q];
                commit_tag_d    = head_q;
            end
            // Issue never targets the head slot while it can commit: that needs a full buffer.
            if (issue_fire) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = next_tag(tail_q);
            end
            if (issue_fire && !commit_fire) begin
                count_d = count_q + TAG_ONE;
            end else if (commit_fire && !issue_fire) begin
                count_d = count_q - TAG_ONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= '0;
            ready_q       <= '0;
            head_q        <= TAG_ONE;
            tail_q        <= TAG_ONE;
            count_q       <= '0;
            commit_q      <= 1'b0;
            commit_reg_q  <= '0;
            commit_data_q <= '0;
            commit_tag_q  <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_q      <= commit_d;
            commit_reg_q  <= commit_reg_d;
            commit_data_q <= commit_data_d;
            commit_tag_q  <= commit_tag_d;
        end
    end

    // NOTE: payload storage has no reset; busy/ready gate every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wb_fire) begin
            data_q[wb_tag] <= wb_data;
        end
        if (issue_fire) begin
            has_rd_q[tail_q] <= issue_has_rd;
            rd_q[tail_q]     <= issue_rd;
        end
    end

    assign commit      = commit_q;
    assign commit_reg  = commit_reg_q;
    assign commit_data = commit_data_q;
    assign commit_tag  = commit_tag_q;
    assign count       = count_q;

`ifdef ROB_BYPASS_EN
    // A result on the bus this cycle is newer than anything stored, so it wins.
    function automatic logic [32:0] lookup(input tag_t t);
        logic [32:0] r;
        r = '0;
        if (t != '0 && busy_q[t]) begin
            if (wb_valid && wb_tag == t) begin
                r = {1'b1, wb_data};
            end else if (ready_q[t]) begin
                r = {1'b1, data_q[t]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {q1_hit, q1_value} = lookup(q1_tag);
        {q2_hit, q2_value} = lookup(q2_tag);
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// compared against a program-order queue model.
module tb_reorder_buffer;
    localparam int TAG_W = 3;
    localparam int DEPTH = 7;

    logic             clk;
    logic             rst;
    logic             pause;
    logic             flush;
    logic             issue_valid;
    logic             issue_has_rd;
    logic [4:0]       issue_rd;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             commit;
    logic [4:0]       commit_reg;
    logic [31:0]      commit_data;
    logic [TAG_W-1:0] commit_tag;
    logic [TAG_W-1:0] count;
`ifdef ROB_BYPASS_EN
    logic [TAG_W-1:0] q1_tag;
    logic [TAG_W-1:0] q2_tag;
    logic             q1_hit;
    logic [31:0]      q1_value;
    logic             q2_hit;
    logic [31:0]      q2_value;
`endif

    reorder_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_has_rd (issue_has_rd),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .issue_tag    (issue_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
`ifdef ROB_BYPASS_EN
        .q1_tag       (q1_tag),
        .q2_tag       (q2_tag),
        .q1_hit       (q1_hit),
        .q1_value     (q1_value),
        .q2_hit       (q2_hit),
        .q2_value     (q2_value),
`endif
        .commit       (commit),
        .commit_reg   (commit_reg),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding instructions in program order.
    typedef struct {
        int          tag;
        bit          has_rd;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    logic        m_commit;
    logic [4:0]  m_creg;
    logic [31:0] m_cdata;
    int          m_ctag;

    task automatic model_reset();
        mq.delete();
        m_tail   = 1;
        m_commit = 1'b0;
        m_creg   = '0;
        m_cdata  = '0;
        m_ctag   = 0;
    endtask

    // Applies one clock edge of the architectural rules to the model, using current inputs.
    task automatic model_edge();
        ent_t e;
        bit   can_issue;
        if (flush) begin
            mq.delete();
            m_tail   = 1;
            m_commit = 1'b0;
            return;
        end
        can_issue = (mq.size() < DEPTH) && !pause;
        if (!pause && mq.size() > 0 && mq[0].ready) begin
            e        = mq.pop_front();
            m_commit = 1'b1;
            m_creg   = e.has_rd ? e.rd : 5'd0;
            m_cdata  = e.data;
            m_ctag   = e.tag;
        end else begin
            m_commit = 1'b0;
        end
        if (wb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(wb_tag)) begin
                    e       = mq[i];
                    e.ready = 1'b1;
                    e.data  = wb_data;
                    mq[i]   = e;
                end
            end
        end
        if (issue_valid && can_issue) begin
            e.tag    = m_tail;
            e.has_rd = issue_has_rd;
            e.rd     = issue_rd;
            e.ready  = 1'b0;
            e.data   = '0;
            mq.push_back(e);
            m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
        end
    endtask

    task automatic idle();
        pause        = 1'b0;
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_has_rd = 1'b0;
        issue_rd     = '0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        wb_data      = '0;
`ifdef ROB_BYPASS_EN
        q1_tag = '0;
        q2_tag = '0;
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic issue_one(input logic has_rd, input logic [4:0] rd);
        idle();
        issue_valid  = 1'b1;
        issue_has_rd = has_rd;
        issue_rd     = rd;
        tick();
        idle();
    endtask

    task automatic writeback(input int tag, input logic [31:0] data);
        idle();
        wb_valid = 1'b1;
        wb_tag   = 3'(tag);
        wb_data  = data;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({commit, commit_reg, commit_data, commit_tag} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_commit: got %0b/%h/%h/%0d want all zero", commit, commit_reg, commit_data, commit_tag);
        end
        n_cmp++;
        if ({issue_ready, issue_tag, count} !== {1'b1, 3'd1, 3'd0}) begin
            n_bad++;
            $display("FAIL reset_ptrs: ready=%0b tag=%0d count=%0d want 1/1/0", issue_ready, issue_tag, count);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_commit();
        do_flush();
        issue_valid  = 1'b1;
        issue_has_rd = 1'b1;
        issue_rd     = 5'd5;
        #1;
        n_cmp++;
        if ({issue_ready, issue_tag} !== {1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL single_issue_tag: ready=%0b tag=%0d want 1/1", issue_ready, issue_tag);
        end
        tick();
        writeback(1, 32'h1234);
        n_cmp++;
        if (commit !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early_commit: got %0b want 0", commit);
        end
        tick();
        n_cmp++;
        if ({commit, commit_reg, commit_data, commit_tag, count} !== {1'b1, 5'd5, 32'h1234, 3'd1, 3'd0}) begin
            n_bad++;
            $display("FAIL single_commit: got %0b/%0d/%h/%0d cnt %0d want 1/5/1234/1 cnt 0",
                     commit, commit_reg, commit_data, commit_tag, count);
        end
        tick();
        n_cmp++;
        if ({commit, commit_data} !== {1'b0, 32'h1234}) begin
            n_bad++;
            $display("FAIL single_pulse_hold: got %0b/%h want 0/1234", commit, commit_data);
        end
    endtask

    task automatic test_full_wrap();
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            issue_valid  = 1'b1;
            issue_has_rd = 1'b1;
            issue_rd     = 5'(i + 1);
            #1;
            n_cmp++;
            if (issue_tag !== 3'(i + 1)) begin
                n_bad++;
                $display("FAIL fill_tag: got %0d want %0d", issue_tag, i + 1);
            end
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if ({count, issue_ready} !== {3'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL full: count=%0d ready=%0b want 7/0", count, issue_ready);
        end
        issue_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 3'd1;
        wb_data     = 32'h77;
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if ({count, issue_ready} !== {3'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL full_reject: count=%0d ready=%0b want 7/0", count, issue_ready);
        end
        tick();
        n_cmp++;
        if ({commit, commit_tag, commit_data, count} !== {1'b1, 3'd1, 32'h77, 3'd6}) begin
            n_bad++;
            $display("FAIL full_commit: got %0b/%0d/%h cnt %0d want 1/1/77 cnt 6", commit, commit_tag, commit_data, count);
        end
        idle();
        #1;
        n_cmp++;
        if ({issue_ready, issue_tag} !== {1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL wrap_tag: ready=%0b tag=%0d want 1/1", issue_ready, issue_tag);
        end
    endtask

    task automatic test_out_of_order();
        do_flush();
        issue_one(1'b1, 5'd3);
        issue_one(1'b0, 5'd9);
        writeback(2, 32'h22);
        n_cmp++;
        if (commit !== 1'b0) begin
            n_bad++;
            $display("FAIL ooo_young_first: got commit %0b want 0", commit);
        end
        writeback(1, 32'h11);
        tick();
        n_cmp++;
        if ({commit, commit_reg, commit_data, commit_tag} !== {1'b1, 5'd3, 32'h11, 3'd1}) begin
            n_bad++;
            $display("FAIL ooo_first: got %0b/%0d/%h/%0d want 1/3/11/1", commit, commit_reg, commit_data, commit_tag);
        end
        tick();
        n_cmp++;
        if ({commit, commit_reg, commit_data, commit_tag} !== {1'b1, 5'd0, 32'h22, 3'd2}) begin
            n_bad++;
            $display("FAIL ooo_second: got %0b/%0d/%h/%0d want 1/0/22/2", commit, commit_reg, commit_data, commit_tag);
        end
    endtask

    task automatic test_pause();
        do_flush();
        issue_one(1'b1, 5'd1);
        issue_one(1'b1, 5'd2);
        writeback(1, 32'hA1);
        for (int k = 0; k < 3; k++) begin
            pause    = 1'b1;
            wb_valid = (k == 0);
            wb_tag   = 3'd2;
            wb_data  = 32'hA2;
            issue_valid = 1'b1;
            #1;
            n_cmp++;
            if (issue_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL pause_ready: got %0b want 0", issue_ready);
            end
            tick();
            n_cmp++;
            if ({commit, count} !== {1'b0, 3'd2}) begin
                n_bad++;
                $display("FAIL pause_hold: commit=%0b count=%0d want 0/2", commit, count);
            end
        end
        idle();
        tick();
        n_cmp++;
        if ({commit, commit_tag, commit_data} !== {1'b1, 3'd1, 32'hA1}) begin
            n_bad++;
            $display("FAIL pause_resume1: got %0b/%0d/%h want 1/1/a1", commit, commit_tag, commit_data);
        end
        tick();
        n_cmp++;
        if ({commit, commit_reg, commit_tag, commit_data} !== {1'b1, 5'd2, 3'd2, 32'hA2}) begin
            n_bad++;
            $display("FAIL pause_resume2: got %0b/%0d/%0d/%h want 1/2/2/a2", commit, commit_reg, commit_tag, commit_data);
        end
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 4; i++) issue_one(1'b1, 5'(10 + i));
        writeback(1, 32'h1);
        flush       = 1'b1;
        issue_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 3'd2;
        wb_data     = 32'h2;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ready: got %0b want 0", issue_ready);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if ({commit, count, issue_ready, issue_tag} !== {1'b0, 3'd0, 1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL flush_state: commit=%0b count=%0d ready=%0b tag=%0d want 0/0/1/1",
                     commit, count, issue_ready, issue_tag);
        end
        tick();
        n_cmp++;
        if (commit !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_no_commit: got %0b want 0", commit);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        issue_one(1'b1, 5'd7);
        issue_one(1'b1, 5'd8);
        writeback(1, 32'hCAFE);
        tick();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({commit, commit_reg, commit_data, commit_tag, count} !== 44'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %0b/%0d/%h/%0d cnt %0d want all zero",
                     commit, commit_reg, commit_data, commit_tag, count);
        end
        n_cmp++;
        if (issue_tag !== 3'd1) begin
            n_bad++;
            $display("FAIL async_reset_tag: got %0d want 1", issue_tag);
        end
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int c = 0; c < 800; c++) begin
            pause        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 39) == 0);
            issue_valid  = ($urandom_range(0, 2) != 0);
            issue_has_rd = 1'($urandom_range(0, 1));
            issue_rd     = 5'($urandom);
            wb_valid     = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wb_tag = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wb_tag = 3'($urandom);
            wb_data = $urandom;
            #1;
            exp_rdy = (mq.size() < DEPTH) && !pause && !flush;
            n_cmp++;
            if (issue_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rand_ready c=%0d: got %0b want %0b", c, issue_ready, exp_rdy);
            end
            if (exp_rdy) begin
                n_cmp++;
                if (issue_tag !== 3'(m_tail)) begin
                    n_bad++;
                    $display("FAIL rand_tag c=%0d: got %0d want %0d", c, issue_tag, m_tail);
                end
            end
            tick();
            n_cmp++;
            if ({commit, commit_reg, commit_data, commit_tag, count} !==
                {m_commit, m_creg, m_cdata, 3'(m_ctag), 3'(mq.size())}) begin
                n_bad++;
                $display("FAIL rand_out c=%0d: got %0b/%0d/%h/%0d cnt %0d want %0b/%0d/%h/%0d cnt %0d",
                         c, commit, commit_reg, commit_data, commit_tag, count,
                         m_commit, m_creg, m_cdata, m_ctag, mq.size());
            end
        end
        idle();
    endtask

`ifdef ROB_BYPASS_EN
    task automatic test_bypass();
        do_flush();
        for (int i = 0; i < 3; i++) issue_one(1'b1, 5'(i + 1));
        writeback(3, 32'hAB);
        q1_tag = 3'd3;
        q2_tag = 3'd2;
        #1;
        n_cmp++;
        if ({q1_hit, q1_value, q2_hit, q2_value} !== {1'b1, 32'hAB, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL bypass_stored: got %0b/%h %0b/%h want 1/ab 0/0", q1_hit, q1_value, q2_hit, q2_value);
        end
        wb_valid = 1'b1;
        wb_tag   = 3'd2;
        wb_data  = 32'h55;
        #1;
        n_cmp++;
        if ({q2_hit, q2_value} !== {1'b1, 32'h55}) begin
            n_bad++;
            $display("FAIL bypass_bus: got %0b/%h want 1/55", q2_hit, q2_value);
        end
        idle();
        do_flush();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_commit();
        test_full_wrap();
        test_out_of_order();
        test_pause();
        test_flush();
        test_async_reset();
`ifdef ROB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
